// File: rtl/alu_pkg.sv
// Shared types and constants for the FASE1 ALU.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  // Opcode values; 5'h0F..5'h1F are reserved and produce a zero result.
  typedef enum logic [4:0] {
    OpAdd   = 5'h00,
    OpSub   = 5'h01,
    OpAnd   = 5'h02,
    OpOr    = 5'h03,
    OpXor   = 5'h04,
    OpNor   = 5'h05,
    OpSll   = 5'h06,
    OpSrl   = 5'h07,
    OpSra   = 5'h08,
    OpSlt   = 5'h09,
    OpSltu  = 5'h0A,
    OpPassA = 5'h0B,
    OpPassB = 5'h0C,
    OpEq    = 5'h0D,
    OpMul   = 5'h0E
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ShSll = 2'd0,
    ShSrl = 2'd1,
    ShSra = 2'd2
  } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [4:0]      shamt,
  input  shift_mode_t     mode,
  output logic [XLEN-1:0] result
);

  // Select shift direction and fill; unused mode encoding yields 0.
  always_comb begin
    result = '0;
    case (mode)
      ShSll:   result = A << shamt;
      ShSrl:   result = A >> shamt;
      ShSra:   result = $signed(A) >>> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 32-bit ALU: combinational operation select followed by a single output register stage.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALU_control,
  input  logic            valid_in,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            carry,
  output logic            overflow,
  output logic            valid_out
);

  logic            w_is_sub;
  logic [XLEN-1:0] w_b_add;
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_shift;
  shift_mode_t     w_shift_mode;
  logic [XLEN-1:0] w_res;
  logic            w_carry;
  logic            w_ovf;
  alu_flags_t      w_flags;

  logic [XLEN-1:0] r_result;
  alu_flags_t      r_flags;
  logic            r_valid;

  // Shared 33-bit adder: subtraction is A + ~B + 1.
  assign w_is_sub = (ALU_control == OpSub);
  assign w_b_add  = w_is_sub ? ~B : B;
  assign w_sum    = {1'b0, A} + {1'b0, w_b_add} + {{XLEN{1'b0}}, w_is_sub};

  // Map shift opcodes onto shifter modes; non-shift ops leave it as SRA (result unused).
  always_comb begin
    w_shift_mode = ShSra;
    if (ALU_control == OpSll) begin
      w_shift_mode = ShSll;
    end else if (ALU_control == OpSrl) begin
      w_shift_mode = ShSrl;
    end
  end

  alu_shifter u_shifter (
    .A      (A),
    .shamt  (B[4:0]),
    .mode   (w_shift_mode),
    .result (w_shift)
  );

  // Operation select; carry/overflow only meaningful on the adder path.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (ALU_control)
      OpAdd, OpSub: begin
        w_res   = w_sum[XLEN-1:0];
        w_carry = w_sum[XLEN];
        w_ovf   = (A[XLEN-1] == w_b_add[XLEN-1]) && (w_sum[XLEN-1] != A[XLEN-1]);
      end
      OpAnd:   w_res = A & B;
      OpOr:    w_res = A | B;
      OpXor:   w_res = A ^ B;
      OpNor:   w_res = ~(A | B);
      OpSll, OpSrl, OpSra: w_res = w_shift;
      OpSlt:   w_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OpSltu:  w_res = {{(XLEN-1){1'b0}}, (A < B)};
      OpPassA: w_res = A;
      OpPassB: w_res = B;
      OpEq:    w_res = {{(XLEN-1){1'b0}}, (A == B)};
      OpMul:   w_res = A * B;
      default: w_res = '0;
    endcase
  end

  // Status flags derived from the combinational result.
  always_comb begin
    w_flags.zero     = (w_res == '0);
    w_flags.negative = w_res[XLEN-1];
    w_flags.carry    = w_carry;
    w_flags.overflow = w_ovf;
  end

  // Output stage: capture on valid_in, hold otherwise; reset clears everything including zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_result <= w_res;
        r_flags  <= w_flags;
      end
    end
  end

  assign result    = r_result;
  assign zero      = r_flags.zero;
  assign negative  = r_flags.negative;
  assign carry     = r_flags.carry;
  assign overflow  = r_flags.overflow;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu with a queue of expected results.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ALU_control;
  logic        valid_in;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic        valid_out;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;   // {zero, negative, carry, overflow}
    string       tag;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  int          errors = 0;
  int          checks = 0;

  alu dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .ALU_control (ALU_control),
    .valid_in    (valid_in),
    .result      (result),
    .zero        (zero),
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow),
    .valid_out   (valid_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {28'b0, zero, negative, carry, overflow};
  endfunction

  // Advance one edge; verify valid_out and either pop a result or confirm hold.
  task automatic tick();
    logic vin;
    exp_t e;
    vin = valid_in;
    @(posedge clk);
    #1;
    chk("valid_out", {31'b0, valid_out}, {31'b0, vin});
    if (vin) begin
      if (q.size() == 0) begin
        chk("queue_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk({e.tag, ".result"}, result, e.res);
        chk({e.tag, ".flags"}, flags_now(), {28'b0, e.fl});
        last = e;
      end
    end else begin
      chk("hold.result", result, last.res);
      chk("hold.flags", flags_now(), {28'b0, last.fl});
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input string tag);
    exp_t e;
    A           = a;
    B           = b;
    ALU_control = op;
    valid_in    = 1'b1;
    e.res = er;
    e.fl  = ef;
    e.tag = tag;
    q.push_back(e);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".result"}, result, 32'd0);
    chk({tag, ".flags"}, flags_now(), 32'd0);
    chk({tag, ".valid_out"}, {31'b0, valid_out}, 32'd0);
  endtask

  initial begin
    last.res = '0;
    last.fl  = '0;
    last.tag = "none";
    // Reset held with a valid ADD presented: outputs must stay cleared.
    rst = 1'b1;
    A = 32'd5;
    B = 32'd3;
    ALU_control = 5'h00;
    valid_in = 1'b1;
    #2;
    chk_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    rst = 1'b0;

    issue(5'h00, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0000, "add_0_1");
    issue(5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, "add_ovf");
    issue(5'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, "add_carry");
    issue(5'h01, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1010, "sub_eq");
    issue(5'h01, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0100, "sub_borrow");
    issue(5'h01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, "sub_ovf");
    issue(5'h09, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, "slt");
    issue(5'h0A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000, "sltu");
    issue(5'h0D, 32'h0000_1234, 32'h0000_1234, 32'h0000_0001, 4'b0000, "eq");
    issue(5'h08, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 4'b0100, "sra31");
    issue(5'h07, 32'h8000_0000, 32'd31,        32'h0000_0001, 4'b0000, "srl31");
    issue(5'h06, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 4'b0000, "sll5");
    issue(5'h08, 32'h8000_0000, 32'd0,         32'h8000_0000, 4'b0100, "sra0");
    issue(5'h02, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100, "and");
    issue(5'h03, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b0100, "or");
    issue(5'h04, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, "xor");
    issue(5'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 4'b0000, "nor");
    issue(5'h0E, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1000, "mul_wrap");
    issue(5'h0E, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 4'b0000, "mul");
    issue(5'h0B, 32'h8000_0001, 32'h0000_0005, 32'h8000_0001, 4'b0100, "passa");
    issue(5'h0C, 32'h8000_0001, 32'h0000_0005, 32'h0000_0005, 4'b0000, "passb");
    issue(5'h1F, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000, "rsvd_1f");
    issue(5'h0F, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1000, "rsvd_0f");

    // Back-to-back ADD then SUB, then drop valid_in to check hold.
    issue(5'h00, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 4'b0000, "b2b_add");
    issue(5'h01, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0, 4'b0100, "b2b_sub");
    valid_in = 1'b0;
    A = 32'hDEAD_BEEF;
    ALU_control = 5'h00;
    tick();
    tick();

    // Reset mid-operation discards the in-flight op.
    issue(5'h00, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 4'b0000, "pre_rst");
    A = 32'd9;
    B = 32'd9;
    ALU_control = 5'h00;
    valid_in = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midop_rst");
    @(posedge clk);
    #1;
    chk_all_zero("midop_rst_edge");
    rst = 1'b0;
    last.res = '0;
    last.fl  = '0;
    issue(5'h00, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000, "post_rst");

    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit integer arithmetic/logic unit for the FASE1 datapath. Takes two 32-bit operands and a 5-bit operation code, computes the selected result plus status flags, and registers them on the next clock edge. It sits between the register-file read ports and the write-back/branch logic.

## Interface
- No parameters; datapath width is fixed at 32.
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- A  input  32  operand A.
- B  input  32  operand B; the shift amount is B[4:0].
- ALU_control  input  5  operation select.
- valid_in  input  1  operands and opcode are valid this cycle.
- result  output  32  registered result.
- zero  output  1  registered; high when the computed result is 0.
- negative  output  1  registered; equals result[31].
- carry  output  1  registered; carry-out for ADD, NOT-borrow for SUB; 0 for other ops.
- overflow  output  1  registered; signed overflow for ADD/SUB; 0 for other ops.
- valid_out  output  1  result and flags were updated by the last edge.

## Operation
- 5'h00 ADD: A+B.
- 5'h01 SUB: A−B.
- 5'h02 AND: A&B.
- 5'h03 OR: A|B.
- 5'h04 XOR: A^B.
- 5'h05 NOR: ~(A|B).
- 5'h06 SLL: A << B[4:0].
- 5'h07 SRL: logical right shift of A by B[4:0].
- 5'h08 SRA: arithmetic right shift of A by B[4:0].
- 5'h09 SLT: 1 if A<B signed, else 0.
- 5'h0A SLTU: 1 if A<B unsigned, else 0.
- 5'h0B PASSA: A.
- 5'h0C PASSB: B.
- 5'h0D EQ: 1 if A==B, else 0.
- 5'h0E MUL: low 32 bits of A*B.
- 5'h0F–5'h1F are reserved. Each produces result 0, zero=1 and all other flags 0; these codes never raise an error.
- Add and subtract use a single 33-bit adder path; subtraction is A + ~B + 1.
  - carry = bit 32 of the adder output.
  - overflow = (A[31]==B'[31]) && (sum[31]!=A[31]), where B' is the adder's B input.
- Shift amounts of 0 return A unchanged; amounts of 31 are legal.
- Computation is fully combinational from the inputs. Only the output stage is registered.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N when valid_in=1 at edge N.
- When valid_in=0 at an edge, result and flags hold their previous values and valid_out drops to 0.
- There is no back-pressure; a new operation can be issued every cycle.
- Reset: asserting rst clears result, zero, negative, carry, overflow and valid_out to 0 immediately, regardless of clk. Note that zero resets to 0, not 1.
- If rst is asserted mid-operation, the in-flight result is discarded. The first valid_in edge after rst is released starts normally.

## Structure
- A shared package alu_pkg holds:
  - the opcode enum alu_op_t (5-bit, values as listed above);
  - the constant XLEN=32;
  - a flags struct {zero, negative, carry, overflow}.
- One sub-module is natural: alu_shifter, a combinational unit for SLL/SRL/SRA with inputs A, shamt and mode.
- Everything else lives in the alu top, consisting of a combinational case on the opcode and an output register stage.

## Test plan
- Reset: assert rst with A=32'd5, B=32'd3, ADD, valid_in=1 → all outputs 0 while rst is high, including zero=0 and valid_out=0.
- ADD: A=0, B=1, op 5'h00 → result=1, zero=0, carry=0, overflow=0, valid_out=1 one cycle later.
  - A=32'h7FFFFFFF, B=1 → result=32'h80000000, overflow=1, negative=1.
  - A=32'hFFFFFFFF, B=1 → result=0, zero=1, carry=1.
- SUB/compare:
  - SUB A=5, B=5 → result=0, zero=1, carry=1.
  - SLT A=32'hFFFFFFFF, B=1 → 1.
  - SLTU with the same operands → 0.
  - EQ A=B=32'h1234 → 1.
- Shifts:
  - SRA A=32'h80000000, B=31 → 32'hFFFFFFFF.
  - SRL with the same operands → 1.
  - SLL A=1, B=32'h25 (amount 5) → 32'h20.
- Logic/other:
  - AND/OR/XOR/NOR on A=32'hF0F0F0F0, B=32'hFF00FF00 → 32'hF000F000 / 32'hFFF0FFF0 / 32'h0FF00FF0 / 32'h000F000F.
  - MUL A=32'h10000, B=32'h10000 → 0 with zero=1.
  - Reserved op 5'h1F → result=0.
- Back-to-back and hold: issue ADD then SUB on consecutive cycles → results on consecutive cycles. Drop valid_in → result holds and valid_out=0.
